// File: rtl/cnn_mul_pkg.sv
// Shared widths and helpers for the arbitrated 14x9 signed multiplier.
package cnn_mul_pkg;

  localparam int A_W   = 14;
  localparam int B_W   = 9;
  localparam int P_W   = 23;
  localparam int CNT_W = 16;

  function automatic int id_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/cnn_mul_arb_pipe.sv
// Enabled NUM_STAGE-deep pipeline carrying valid, id and the signed product.
// The multiply happens on the way into the first stage; the whole pipe freezes when en is low.
module cnn_mul_arb_pipe
  import cnn_mul_pkg::*;
#(
  parameter int NUM_STAGE = 2,
  parameter int ID_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [ID_W-1:0]       in_id,
  input  logic [A_W-1:0]        in_a,
  input  logic [B_W-1:0]        in_b,
  output logic                  out_valid,
  output logic [ID_W-1:0]       out_id,
  output logic signed [P_W-1:0] out_p
);

  logic [NUM_STAGE-1:0]  vld_q, vld_d;
  logic [ID_W-1:0]       id_q [NUM_STAGE];
  logic [ID_W-1:0]       id_d [NUM_STAGE];
  logic signed [P_W-1:0] p_q  [NUM_STAGE];
  logic signed [P_W-1:0] p_d  [NUM_STAGE];
  logic signed [P_W-1:0] a_ext_s, b_ext_s, prod_s;

  // Operands sign-extended to the full product width so no bits are lost.
  assign a_ext_s = {{(P_W-A_W){in_a[A_W-1]}}, in_a};
  assign b_ext_s = {{(P_W-B_W){in_b[B_W-1]}}, in_b};
  assign prod_s  = a_ext_s * b_ext_s;

  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    p_d   = p_q;
    if (en) begin
      vld_d[0] = in_valid;
      id_d[0]  = in_valid ? in_id  : '0;
      p_d[0]   = in_valid ? prod_s : '0;
      for (int k = 1; k < NUM_STAGE; k++) begin
        vld_d[k] = vld_q[k-1];
        id_d[k]  = id_q[k-1];
        p_d[k]   = p_q[k-1];
      end
    end else begin
      vld_d = vld_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < NUM_STAGE; k++) begin
        id_q[k] <= '0;
        p_q[k]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
      p_q   <= p_d;
    end
  end

  assign out_valid = vld_q[NUM_STAGE-1];
  assign out_id    = id_q[NUM_STAGE-1];
  assign out_p     = p_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mul_arb_14s_9s.sv
// Round-robin arbiter sharing one pipelined 14s x 9s multiplier among NUM_REQ requesters.
// Optional per-requester saturating grant counters when CNN_MUL_ARB_PERF_EN is defined.
module cnn_mul_arb_14s_9s
  import cnn_mul_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_STAGE = 2,
  localparam int ID_W      = id_w(NUM_REQ)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*A_W-1:0]   req_a,
  input  logic [NUM_REQ*B_W-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic signed [P_W-1:0]    rsp_p
`ifdef CNN_MUL_ARB_PERF_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] perf_cnt
`endif
);

  localparam int CW = ID_W + 1;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] gnt_idx_s;
  logic [CW-1:0]   cand_s;
  logic            gnt_found_s, adv_s, xfer_s;
  logic [A_W-1:0]  a_s;
  logic [B_W-1:0]  b_s;

  assign adv_s  = !rsp_valid | rsp_ready;
  assign xfer_s = adv_s & gnt_found_s & ap_rst_n;

  // Search from rr_ptr upward, wrapping, for the first valid requester.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s = {1'b0, rr_ptr_q} + CW'(off);
      if (cand_s >= CW'(NUM_REQ)) begin
        cand_s = cand_s - CW'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_found_s && req_valid[cand_s[ID_W-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s[ID_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (xfer_s) begin
      req_ready[gnt_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign a_s = req_a[gnt_idx_s*A_W +: A_W];
  assign b_s = req_b[gnt_idx_s*B_W +: B_W];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer_s) begin
      if (gnt_idx_s == ID_W'(NUM_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_s + ID_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  cnn_mul_arb_pipe #(
    .NUM_STAGE (NUM_STAGE),
    .ID_W      (ID_W)
  ) u_pipe (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .en        (adv_s),
    .in_valid  (xfer_s),
    .in_id     (gnt_idx_s),
    .in_a      (a_s),
    .in_b      (b_s),
    .out_valid (rsp_valid),
    .out_id    (rsp_id),
    .out_p     (rsp_p)
  );

`ifdef CNN_MUL_ARB_PERF_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];

  // Counts stick at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer_s && (gnt_idx_s == ID_W'(i)) && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_cnn_mul_arb_14s_9s.sv
// Directed self-checking bench for cnn_mul_arb_14s_9s (NUM_REQ=4, NUM_STAGE=2).
module tb_cnn_mul_arb_14s_9s;
  import cnn_mul_pkg::*;

  localparam int NR = 4;
  localparam int NS = 2;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst_n = 1'b0;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_ready;
  logic [NR*A_W-1:0]     req_a;
  logic [NR*B_W-1:0]     req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic signed [P_W-1:0] rsp_p;
`ifdef CNN_MUL_ARB_PERF_EN
  logic [NR*CNT_W-1:0]   perf_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int ep [4] = '{300, 1400, -2096896, -2088960};

  cnn_mul_arb_14s_9s #(.NUM_REQ(NR), .NUM_STAGE(NS)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
`ifdef CNN_MUL_ARB_PERF_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input logic signed [31:0] act,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input int id, input int p);
    check_eq({tag, ".valid"}, rsp_valid, v);
    if (v) begin
      check_eq({tag, ".id"}, rsp_id, id);
      check_eq({tag, ".p"}, rsp_p, p);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*A_W +: A_W] = 14'(a);
    req_b[i*B_W +: B_W] = 9'(b);
  endtask

  task automatic send_one(input string tag, input int idx, input int a, input int b,
                          input int exp_p);
    @(negedge ap_clk);
    set_op(idx, a, b);
    req_valid = 4'(1 << idx);
    #1;
    check_eq({tag, ".ready"}, req_ready, 1 << idx);
    @(negedge ap_clk);
    req_valid = 4'b0000;
    @(negedge ap_clk);
    chk_out(tag, 1'b1, idx, exp_p);
  endtask

  initial begin
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    set_op(0, 100, 3);
    set_op(1, -200, -7);
    set_op(2, 8191, -256);
    set_op(3, -8192, 255);
    req_valid = 4'b1111;

    // Reset state with every requester asking.
    repeat (2) @(negedge ap_clk);
    #1;
    check_eq("rst.valid", rsp_valid, 0);
    check_eq("rst.id", rsp_id, 0);
    check_eq("rst.p", rsp_p, 0);
    check_eq("rst.ready", req_ready, 0);

    // First transfer right on the first edge after release; requester 1 only.
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    set_op(1, -8192, -256);
    req_valid = 4'b0010;
    #1;
    check_eq("single.ready", req_ready, 2);
    @(negedge ap_clk);
    req_valid = 4'b0000;
    check_eq("single.lat1", rsp_valid, 0);
    @(negedge ap_clk);
    chk_out("single", 1'b1, 1, 2097152);
    @(negedge ap_clk);
    check_eq("single.drain", rsp_valid, 0);

    // Operand extremes.
    send_one("ext_pos", 2, 8191, 255, 2088705);
    send_one("ext_neg", 3, -8192, 255, -2088960);

    set_op(1, -200, -7);
    set_op(2, 8191, -256);
    set_op(3, -8192, 255);

    // Continuous round robin at full rate.
    for (int k = 0; k < 10; k++) begin
      @(negedge ap_clk);
      if (k >= 2) chk_out("rr", 1'b1, (k - 2) % 4, ep[(k - 2) % 4]);
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) check_eq("rr.gnt", req_ready, 1 << (k % 4));
    end
    @(negedge ap_clk);
    check_eq("rr.drain", rsp_valid, 0);

    // Three-cycle back-pressure with a full pipe.
    @(negedge ap_clk);
    req_valid = 4'b1111;
    #1;
    check_eq("stall.g0", req_ready, 1);
    @(negedge ap_clk);
    check_eq("stall.empty", rsp_valid, 0);
    #1;
    check_eq("stall.g1", req_ready, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      chk_out("stall.hold", 1'b1, 0, 300);
      rsp_ready = 1'b0;
      #1;
      check_eq("stall.ready", req_ready, 0);
    end
    @(negedge ap_clk);
    chk_out("stall.rel", 1'b1, 0, 300);
    rsp_ready = 1'b1;
    #1;
    check_eq("stall.g2", req_ready, 4);
    @(negedge ap_clk);
    chk_out("stall.r1", 1'b1, 1, 1400);
    #1;
    check_eq("stall.g3", req_ready, 8);
    @(negedge ap_clk);
    chk_out("stall.r2", 1'b1, 2, -2096896);
    req_valid = 4'b0000;
    @(negedge ap_clk);
    chk_out("stall.r3", 1'b1, 3, -2088960);
    @(negedge ap_clk);
    check_eq("stall.drain", rsp_valid, 0);

    // Reset with two products in flight and rr_ptr away from zero.
    @(negedge ap_clk);
    req_valid = 4'b0110;
    #1;
    check_eq("mid.g1", req_ready, 2);
    @(negedge ap_clk);
    #1;
    check_eq("mid.g2", req_ready, 4);
    @(negedge ap_clk);
    chk_out("mid.r1", 1'b1, 1, 1400);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    ap_rst_n  = 1'b0;
    #1;
    check_eq("mid.rst.valid", rsp_valid, 0);
    check_eq("mid.rst.id", rsp_id, 0);
    check_eq("mid.rst.p", rsp_p, 0);
    check_eq("mid.rst.ready", req_ready, 0);
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check_eq("mid.rr0", req_ready, 1);
    @(negedge ap_clk);
    req_valid = 4'b0000;
    check_eq("mid.stale", rsp_valid, 0);
    @(negedge ap_clk);
    chk_out("mid.new", 1'b1, 0, 300);
    @(negedge ap_clk);
    check_eq("mid.drain", rsp_valid, 0);

`ifdef CNN_MUL_ARB_PERF_EN
    // Saturation of requester 0's grant counter.
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    req_valid = 4'b0001;
    repeat (70000) @(negedge ap_clk);
    req_valid = 4'b0010;
    repeat (3) @(negedge ap_clk);
    req_valid = 4'b0100;
    repeat (5) @(negedge ap_clk);
    req_valid = 4'b0000;
    @(negedge ap_clk);
    check_eq("perf0", perf_cnt[15:0], 65535);
    check_eq("perf1", perf_cnt[31:16], 3);
    check_eq("perf2", perf_cnt[47:32], 5);
    check_eq("perf3", perf_cnt[63:48], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_mul_arb_14s_9s.md
CNN_MUL_ARB_14S_9S -- requirements
Module: cnn_mul_arb_14s_9s

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one multiplier (range 1..8).
REQ-002 SHALL have parameter NUM_STAGE, default 2: multiplier pipeline depth in cycles (range 1..4).
REQ-003 SHALL have port ap_clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-006 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept, at most one bit high.
REQ-007 SHALL have port req_a, input, NUM_REQ*14 bits: signed 14-bit operand A, requester i at [14*i +: 14].
REQ-008 SHALL have port req_b, input, NUM_REQ*9 bits: signed 9-bit operand B, requester i at [9*i +: 9].
REQ-009 SHALL have port rsp_valid, output, 1 bit: result valid.
REQ-010 SHALL have port rsp_ready, input, 1 bit: consumer accepts result.
REQ-011 SHALL have port rsp_id, output, max(1,$clog2(NUM_REQ)) bits: index of the requester owning rsp_p.
REQ-012 SHALL have port rsp_p, output, 23 bits: signed product.

Function
REQ-013 SHALL compute rsp_p = signed(a) * signed(b), full 23-bit width, no truncation or rounding.
REQ-014 SHALL arbitrate round-robin: grant the lowest index >= rr_ptr with req_valid high, wrapping modulo NUM_REQ.
REQ-015 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ on each accepted transfer, and leave it unchanged otherwise.
REQ-016 SHALL define adv = !rsp_valid | rsp_ready; all pipeline stages shift only when adv is high.
REQ-017 SHALL drive req_ready[i] high combinationally only when adv is high and i is the granted index.
REQ-018 SHALL treat a transfer as req_valid[i] & req_ready[i]; operands are captured on that edge.
REQ-019 SHALL present the result with rsp_valid high exactly NUM_STAGE cycles after the transfer edge when there are no stalls.
REQ-020 SHALL hold rsp_valid, rsp_id and rsp_p stable, with all stages frozen, while rsp_valid & !rsp_ready.
REQ-021 SHALL insert a bubble (stage valid = 0) on cycles with adv high and no request; bubbles do not block later stages.
REQ-022 SHALL sustain one transfer per cycle when rsp_ready is held high.
REQ-023 SHALL, with NUM_REQ = 1, tie the grant to requester 0 and drive rsp_id = 0.
REQ-024 Requesters SHALL hold req_valid and their operands until accepted; the arbiter does not depend on this for correctness.

Reset
REQ-025 SHALL, while ap_rst_n is low, clear all stage valid bits, set rsp_valid = 0, rsp_id = 0, rsp_p = 0 and rr_ptr = 0, and drive req_ready = 0.
REQ-026 SHALL discard in-flight products on reset mid-operation; no result is emitted for them after release.
REQ-027 SHALL allow the first transfer on the first rising edge after ap_rst_n deasserts.

Configuration
REQ-028 SHALL, with CNN_MUL_ARB_PERF_EN defined:
- add output perf_cnt, NUM_REQ*16 bits;
- keep one 16-bit saturating count of accepted transfers per requester;
- reset the counts to 0;
- hold each count at 0xFFFF once reached.
REQ-029 SHALL, without CNN_MUL_ARB_PERF_EN, omit the perf_cnt port and the counter logic entirely.

Structure
REQ-030 SHALL place A_W = 14, B_W = 9, P_W = 23 and the ID-width function in shared package cnn_mul_pkg.
REQ-031 SHALL instantiate one sub-module, cnn_mul_arb_pipe:
- NUM_STAGE-deep enabled pipeline;
- carries valid, id and product;
- performs the signed multiply in its first stage.

Verification
REQ-032 Single requester: NUM_STAGE = 2, requester 1 sends a = -8192, b = -256 -> two cycles later rsp_valid = 1, rsp_id = 1, rsp_p = 2097152.
REQ-033 All four requesters valid continuously, rsp_ready = 1 -> grants in order 0,1,2,3,0,...; one result per cycle; rsp_p correct for each.
REQ-034 rsp_ready low for 3 cycles with a full pipeline -> req_ready = 0 throughout, outputs stable, no result lost or duplicated after release.
REQ-035 ap_rst_n pulsed low while 2 products are in flight -> rsp_valid = 0, rr_ptr = 0, and no stale result after release.
REQ-036 Extremes a = 8191, b = 255 and a = -8192, b = 255 -> rsp_p = 2088705 and -2088960.
REQ-037 CNN_MUL_ARB_PERF_EN defined, 70000 grants to requester 0 -> perf_cnt[15:0] = 0xFFFF, other counts exact.
